uart_tx_sequencer: RTL and testbench

UART_TX_SEQUENCER -- requirements
Module: uart_tx_sequencer

---
 rtl/tlul_pkg.sv | 85 ++++++++
 rtl/top_pkg.sv | 7 +
 rtl/uart_seq_pkg.sv | 21 ++
 rtl/uart_seq_fifo.sv | 46 ++++
 rtl/uart_tx_sequencer.sv | 157 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 273 +++++++++++++++++++++++++++
 6 files changed

// File: rtl/tlul_pkg.sv
// TL-UL request/response bundles and the A-channel user/integrity helper.
// The integrity code is a fold over the command and data fields.
package tlul_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  localparam logic [3:0] InstrTypeData = 4'h9;

  typedef struct packed {
    logic [4:0] rsvd;
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  localparam tl_a_user_t TL_A_USER_DEFAULT = '{
    rsvd:       5'd0,
    instr_type: InstrTypeData,
    cmd_intg:   7'd0,
    data_intg:  7'd0
  };

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  function automatic logic [6:0] intg_fold(input logic [63:0] v);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r = {r[5:0], r[6] ^ v[i]};
    end
    return r;
  endfunction

  function automatic tl_a_user_t a_user_gen(
    input tl_a_op_e    op,
    input logic [31:0] addr,
    input logic [3:0]  mask,
    input logic [31:0] data
  );
    tl_a_user_t u;
    u = TL_A_USER_DEFAULT;
    u.cmd_intg = intg_fold({17'd0, u.instr_type, addr, op, mask, 4'd0});
    u.data_intg = intg_fold({32'd0, data});
    return u;
  endfunction

endpackage

// File: rtl/top_pkg.sv
// Top-level address map constants shared across the SoC.
// Only the UART base is consumed by the console sequencer.
package top_pkg;

  localparam logic [31:0] UART_BASE = 32'h4000_0000;

endpackage

// File: rtl/uart_seq_pkg.sv
// Console sequencer states and UART register map.
// Offsets are relative to the UART base address.
package uart_seq_pkg;

  typedef enum logic [2:0] {
    CFG_REQ,
    CFG_RSP,
    IDLE,
    POLL_REQ,
    POLL_RSP,
    WR_REQ,
    WR_RSP,
    HALT
  } seq_state_e;

  localparam logic [31:0] UART_CTRL_OFF   = 32'h10;
  localparam logic [31:0] UART_STATUS_OFF = 32'h14;
  localparam logic [31:0] UART_WDATA_OFF  = 32'h1c;
  localparam int          STATUS_TXFULL_BIT = 0;

endpackage

// File: rtl/uart_seq_fifo.sv
// Byte FIFO with an extra pointer wrap bit to tell full from empty.
// Depth must be a power of two, at least 2.
module uart_seq_fifo #(
  parameter int Depth = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(Depth);

  logic [7:0]  r_mem [Depth];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr;
  logic        w_rd;

  assign w_wr = push_i && !full_o;
  assign w_rd = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rptr[AW-1:0]];
  assign empty_o = r_wptr == r_rptr;
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/uart_tx_sequencer.sv
// Configures the UART once, then drains console bytes into WDATA,
// polling STATUS.TXFULL before every write over a single TL-UL port.
module uart_tx_sequencer
  import tlul_pkg::*;
  import uart_seq_pkg::*;
#(
  parameter logic [31:0] UartBase  = top_pkg::UART_BASE,
  parameter logic [15:0] NcoVal    = 16'd1024,
  parameter int          FifoDepth = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i,
  output logic        cfg_done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [15:0] tx_count_o
);

  seq_state_e  r_state;
  seq_state_e  w_next;
  logic        r_armed;
  logic        r_cfg_done;
  logic        r_err;
  logic [15:0] r_tx_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [7:0]  w_head;
  logic        w_a_valid;
  logic        w_a_hs;
  tl_a_op_e    w_op;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        w_in_rsp;
  logic        w_d_ok;
  logic        w_d_bad;
  logic        w_unused_d;

  assign byte_ready_o = !w_full && (r_state != HALT);
  assign w_push = byte_valid_i && byte_ready_o;
  assign w_a_hs = w_a_valid && tl_i.a_ready;
  assign w_pop  = (r_state == WR_REQ) && w_a_hs;

  uart_seq_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (byte_data_i),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_in_rsp = (r_state == CFG_RSP) ||
                    (r_state == POLL_RSP) ||
                    (r_state == WR_RSP);
  assign w_d_ok  = tl_i.d_valid && !tl_i.d_error;
  assign w_d_bad = tl_i.d_valid && tl_i.d_error;

  always_comb begin
    w_next    = r_state;
    w_a_valid = 1'b0;
    w_op      = PutFullData;
    w_addr    = UartBase + UART_CTRL_OFF;
    w_data    = {NcoVal, 15'b0, 1'b1};
    unique case (r_state)
      CFG_REQ: begin
        w_a_valid = r_armed;
        if (w_a_hs) w_next = CFG_RSP;
      end
      CFG_RSP: begin
        if (w_d_bad)     w_next = HALT;
        else if (w_d_ok) w_next = IDLE;
      end
      IDLE: begin
        if (!w_empty || w_push) w_next = POLL_REQ;
      end
      POLL_REQ: begin
        w_a_valid = 1'b1;
        w_op      = Get;
        w_addr    = UartBase + UART_STATUS_OFF;
        w_data    = '0;
        if (w_a_hs) w_next = POLL_RSP;
      end
      POLL_RSP: begin
        if (w_d_bad) begin
          w_next = IDLE;
        end else if (w_d_ok) begin
          if (tl_i.d_data[STATUS_TXFULL_BIT]) w_next = POLL_REQ;
          else                                w_next = WR_REQ;
        end
      end
      WR_REQ: begin
        w_a_valid = 1'b1;
        w_addr    = UartBase + UART_WDATA_OFF;
        w_data    = {24'b0, w_head};
        if (w_a_hs) w_next = WR_RSP;
      end
      WR_RSP: begin
        if (tl_i.d_valid) w_next = IDLE;
      end
      HALT: w_next = HALT;
      default: w_next = HALT;
    endcase
  end

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = w_a_valid;
    tl_o.a_opcode  = w_op;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = 8'd0;
    tl_o.a_address = w_addr;
    tl_o.a_mask    = 4'hF;
    tl_o.a_data    = w_data;
    tl_o.a_user    = a_user_gen(w_op, w_addr, 4'hF, w_data);
    tl_o.d_ready   = 1'b1;
  end

  // r_armed holds off the first CTRL request for one cycle out of reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= CFG_REQ;
      r_armed    <= 1'b0;
      r_cfg_done <= 1'b0;
      r_err      <= 1'b0;
      r_tx_cnt   <= 16'd0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
      if (r_state == CFG_RSP && w_d_ok) r_cfg_done <= 1'b1;
      if (w_in_rsp && w_d_bad) r_err <= 1'b1;
      if (r_state == WR_RSP && w_d_ok) r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

  assign cfg_done_o = r_cfg_done;
  assign err_o      = r_err;
  assign tx_count_o = r_tx_cnt;
  assign busy_o     = (r_state != IDLE) || !w_empty;

  assign w_unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size,
                        tl_i.d_source, tl_i.d_sink, tl_i.d_user,
                        tl_i.d_data[31:1]};

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for the UART console sequencer: a small TL-UL UART model
// checks every request against a queue of expected bytes.
module tb_uart_tx_sequencer;
  import tlul_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        byte_valid_i;
  logic [7:0]  byte_data_i;
  logic        byte_ready_o;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;
  logic        cfg_done_o;
  logic        busy_o;
  logic        err_o;
  logic [15:0] tx_count_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ctrl  = 0;
  int n_get   = 0;
  int n_wr    = 0;

  logic [7:0]  exp_q  [$];
  logic [31:0] stat_q [$];
  logic        ready_hold = 1'b0;
  logic        err_ctrl   = 1'b0;
  int          err_wr_at  = -1;

  always #5 clk_i = ~clk_i;

  uart_tx_sequencer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .tl_o         (tl_o),
    .tl_i         (tl_i),
    .cfg_done_o   (cfg_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o),
    .tx_count_o   (tx_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // UART model: one request at a time, a_ready and d_valid never
  // in the same cycle as the request first appears.
  initial begin : uart_model
    tl_h2d_t     req;
    logic        rsp_err;
    logic [31:0] rsp_data;
    tl_i = '0;
    forever begin
      @(negedge clk_i);
      if (tl_o.a_valid && !ready_hold && !rst_i) begin
        req = tl_o;
        tl_i.a_ready = 1'b1;
        @(negedge clk_i);
        tl_i.a_ready = 1'b0;
        rsp_err  = 1'b0;
        rsp_data = '0;
        chk("a_fixed", {21'd0, req.a_size, req.a_mask,
                        req.a_source, req.a_param, req.d_ready},
            {21'd0, 2'd2, 4'hF, 8'd0, 3'd0, 1'b1});
        case (req.a_address)
          BASE + 32'h10: begin
            n_ctrl++;
            chk("ctrl_op", 32'(req.a_opcode), 32'(PutFullData));
            chk("ctrl_data", req.a_data, 32'h0400_0001);
            rsp_err = err_ctrl;
          end
          BASE + 32'h14: begin
            n_get++;
            chk("poll_op", 32'(req.a_opcode), 32'(Get));
            if (stat_q.size() > 0) rsp_data = stat_q.pop_front();
          end
          BASE + 32'h1c: begin
            n_wr++;
            chk("wr_op", 32'(req.a_opcode), 32'(PutFullData));
            chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0)
              chk("wdata", req.a_data, {24'd0, exp_q.pop_front()});
            rsp_err = (n_wr == err_wr_at);
          end
          default: chk("a_address", req.a_address, BASE);
        endcase
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        tl_i.d_valid  = 1'b1;
        tl_i.d_error  = rsp_err;
        tl_i.d_data   = rsp_data;
        tl_i.d_opcode = (req.a_opcode == Get) ? AccessAckData : AccessAck;
        @(negedge clk_i);
        tl_i.d_valid = 1'b0;
        tl_i.d_error = 1'b0;
        tl_i.d_data  = '0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_byte(input logic [7:0] b);
    int t;
    t = 0;
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    while (!byte_ready_o && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    chk("push_ready", 32'(byte_ready_o), 32'd1);
    if (byte_ready_o) exp_q.push_back(b);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy_o && t < 5000) begin
      @(negedge clk_i);
      t++;
    end
    chk(tag, 32'(busy_o), 32'd0);
  endtask

  task automatic wait_ctrl(input string tag, input int tgt);
    int t;
    t = 0;
    while (n_ctrl < tgt && t < 2000) begin
      @(negedge clk_i);
      t++;
    end
    chk(tag, 32'(n_ctrl >= tgt), 32'd1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    exp_q.delete();
    stat_q.delete();
    rst_i = 1'b0;
  endtask

  initial begin : stim
    int g0;
    int w0;
    int c0;
    int av;
    rst_i = 1'b1;
    byte_valid_i = 1'b0;
    byte_data_i  = 8'h00;
    repeat (3) @(negedge clk_i);

    chk("rst_avalid", 32'(tl_o.a_valid), 32'd0);
    chk("rst_bready", 32'(byte_ready_o), 32'd1);
    chk("rst_cfgdone", 32'(cfg_done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_txcnt", 32'(tx_count_o), 32'd0);
    rst_i = 1'b0;
    #1;
    chk("cyc1_avalid", 32'(tl_o.a_valid), 32'd0);
    @(negedge clk_i);
    chk("cyc2_avalid", 32'(tl_o.a_valid), 32'd1);
    chk("cyc2_addr", tl_o.a_address, BASE + 32'h10);
    wait_idle("cfg_idle");
    chk("cfg_done", 32'(cfg_done_o), 32'd1);
    chk("cfg_count", 32'(n_ctrl), 32'd1);

    push_byte(8'h48);
    chk("lat_avalid", 32'(tl_o.a_valid), 32'd1);
    chk("lat_op", 32'(tl_o.a_opcode), 32'(Get));
    push_byte(8'h69);
    wait_idle("hi_idle");
    chk("hi_txcnt", 32'(tx_count_o), 32'd2);
    chk("hi_nwr", 32'(n_wr), 32'd2);

    stat_q = '{32'd1, 32'd1, 32'd1, 32'd0};
    g0 = n_get;
    push_byte(8'h58);
    wait_idle("txfull_idle");
    chk("txfull_gets", 32'(n_get - g0), 32'd4);
    chk("txfull_txcnt", 32'(tx_count_o), 32'd3);

    ready_hold = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
    byte_valid_i = 1'b1;
    byte_data_i  = 8'hFF;
    #1;
    chk("full_bready", 32'(byte_ready_o), 32'd0);
    chk("full_busy", 32'(busy_o), 32'd1);
    @(negedge clk_i);
    byte_valid_i = 1'b0;
    ready_hold = 1'b0;
    wait_idle("full_idle");
    chk("full_txcnt", 32'(tx_count_o), 32'd11);
    chk("full_drained", 32'(exp_q.size()), 32'd0);

    do_reset();
    wait_idle("r2_cfg_idle");
    w0 = n_wr;
    err_wr_at = n_wr + 2;
    push_byte(8'h31);
    push_byte(8'h32);
    push_byte(8'h33);
    wait_idle("werr_idle");
    err_wr_at = -1;
    chk("werr_err", 32'(err_o), 32'd1);
    chk("werr_txcnt", 32'(tx_count_o), 32'd2);
    chk("werr_nwr", 32'(n_wr - w0), 32'd3);

    ready_hold = 1'b1;
    push_byte(8'h5A);
    repeat (3) @(negedge clk_i);
    chk("mid_avalid", 32'(tl_o.a_valid), 32'd1);
    chk("mid_op", 32'(tl_o.a_opcode), 32'(Get));
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rst_avalid", 32'(tl_o.a_valid), 32'd0);
    chk("mid_rst_txcnt", 32'(tx_count_o), 32'd0);
    chk("mid_rst_err", 32'(err_o), 32'd0);
    exp_q.delete();
    @(negedge clk_i);
    c0 = n_ctrl;
    w0 = n_wr;
    rst_i = 1'b0;
    ready_hold = 1'b0;
    wait_ctrl("mid_cfg_reissue", c0 + 1);
    wait_idle("mid_idle");
    chk("mid_cfgdone", 32'(cfg_done_o), 32'd1);
    chk("mid_fifo_lost", 32'(n_wr - w0), 32'd0);

    err_ctrl = 1'b1;
    c0 = n_ctrl;
    do_reset();
    wait_ctrl("halt_ctrl", c0 + 1);
    repeat (5) @(negedge clk_i);
    err_ctrl = 1'b0;
    chk("halt_err", 32'(err_o), 32'd1);
    chk("halt_bready", 32'(byte_ready_o), 32'd0);
    chk("halt_cfgdone", 32'(cfg_done_o), 32'd0);
    byte_valid_i = 1'b1;
    byte_data_i  = 8'h77;
    av = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (tl_o.a_valid) av++;
    end
    byte_valid_i = 1'b0;
    chk("halt_no_avalid", 32'(av), 32'd0);
    chk("halt_busy", 32'(busy_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
